btn_conditioner: RTL and testbench

Parametrised successor to the fixed 3-button debouncer. It conditions N asynchronous push-button inputs into clean levels, single-cycle press and release pulses, and optional hold-to-repeat press pulses for cursor-style controls. It sits between the `ui_in` button pins and the game core. A shared prescaler keeps per-channel counters narrow, and a debug bypass mode is included.

---
 rtl/btn_pkg.sv | 34 +++
 rtl/btn_channel.sv | 166 ++++++++++++++++
 rtl/btn_conditioner.sv | 59 +++++
 tb/tb_btn_conditioner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types, default configuration and width helpers for the button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    localparam int          DEF_N_BUTTONS    = 32'sd3;
    localparam int          DEF_PRESCALE     = 32'sd25000;
    localparam int          DEF_STABLE_TICKS = 32'sd20;
    localparam int          DEF_REPEAT_DELAY = 32'sd400;
    localparam int          DEF_REPEAT_RATE  = 32'sd100;
    localparam logic [31:0] DEF_REPEAT_MASK  = 32'h0000_0006;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int CNT_W(input int max_val);
        if (max_val < 32'sd1) begin
            return 32'sd1;
        end else begin
            return $clog2(max_val + 32'sd1);
        end
    endfunction

    function automatic int max2(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, tick-based debounce, pulse registers and,
// when BTN_AUTOREPEAT_EN is defined, the hold-to-repeat FSM.
module btn_channel
    import btn_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter bit REPEAT_EN    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic e_debug,
    input  logic tick,
    input  logic btn_in,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int            DB_W    = CNT_W(STABLE_TICKS);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(STABLE_TICKS - 32'sd1);

    logic            sync1_r;
    logic            sync_r;
    logic            level_r;
    logic            press_r;
    logic            release_r;
    logic [DB_W-1:0] db_cnt_r;
    logic [DB_W-1:0] db_cnt_nxt_s;
    logic            level_nxt_s;
    logic            rise_s;
    logic            fall_s;
    logic            rep_fire_s;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync_r  <= 1'b0;
        end else begin
            sync1_r <= btn_in;
            sync_r  <= sync1_r;
        end
    end

    // Debounce decision; bypass copies the synchronised level straight through
    always_comb begin
        level_nxt_s  = level_r;
        db_cnt_nxt_s = db_cnt_r;
        rise_s       = 1'b0;
        fall_s       = 1'b0;
        if (e_debug) begin
            level_nxt_s  = sync_r;
            db_cnt_nxt_s = '0;
            rise_s       = sync_r & ~level_r;
            fall_s       = ~sync_r & level_r;
        end else if (sync_r == level_r) begin
            db_cnt_nxt_s = '0;
        end else if (tick) begin
            if (db_cnt_r == DB_LAST) begin
                level_nxt_s  = ~level_r;
                db_cnt_nxt_s = '0;
                rise_s       = ~level_r;
                fall_s       = level_r;
            end else begin
                db_cnt_nxt_s = db_cnt_r + DB_W'(1);
            end
        end else begin
            db_cnt_nxt_s = db_cnt_r;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int              RP_W       = CNT_W(max2(REPEAT_DELAY, REPEAT_RATE));
    localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 32'sd1);
    localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 32'sd1);

    rep_state_t      state_r;
    rep_state_t      state_nxt_s;
    logic [RP_W-1:0] rp_cnt_r;
    logic [RP_W-1:0] rp_cnt_nxt_s;

    // Repeat FSM state and tick counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            rp_cnt_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            rp_cnt_r <= rp_cnt_nxt_s;
        end
    end

    // A debounced fall always wins over a repeat due on the same tick
    always_comb begin
        state_nxt_s  = state_r;
        rp_cnt_nxt_s = rp_cnt_r;
        rep_fire_s   = 1'b0;
        if (!REPEAT_EN || e_debug || fall_s) begin
            state_nxt_s  = IDLE;
            rp_cnt_nxt_s = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        state_nxt_s  = DELAY;
                        rp_cnt_nxt_s = '0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                DELAY: begin
                    if (tick && (rp_cnt_r == DELAY_LAST)) begin
                        rep_fire_s   = 1'b1;
                        rp_cnt_nxt_s = '0;
                        state_nxt_s  = REPEAT;
                    end else if (tick) begin
                        rp_cnt_nxt_s = rp_cnt_r + RP_W'(1);
                    end else begin
                        rp_cnt_nxt_s = rp_cnt_r;
                    end
                end
                REPEAT: begin
                    if (tick && (rp_cnt_r == RATE_LAST)) begin
                        rep_fire_s   = 1'b1;
                        rp_cnt_nxt_s = '0;
                    end else if (tick) begin
                        rp_cnt_nxt_s = rp_cnt_r + RP_W'(1);
                    end else begin
                        rp_cnt_nxt_s = rp_cnt_r;
                    end
                end
                default: begin
                    state_nxt_s  = IDLE;
                    rp_cnt_nxt_s = '0;
                end
            endcase
        end
    end
`else
    logic unused_repeat_cfg_s;
    assign unused_repeat_cfg_s = ^{REPEAT_DELAY[0], REPEAT_RATE[0], REPEAT_EN};
    assign rep_fire_s          = 1'b0;
`endif

    // Level, counter and single-cycle pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            db_cnt_r  <= '0;
        end else begin
            level_r   <= level_nxt_s;
            press_r   <= rise_s | rep_fire_s;
            release_r <= fall_s;
            db_cnt_r  <= db_cnt_nxt_s;
        end
    end

    assign level         = level_r;
    assign press         = press_r;
    assign release_pulse = release_r;

endmodule

// File: rtl/btn_conditioner.sv
// N-channel push-button conditioner with a shared tick prescaler.
// Hold-to-repeat is built only when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int                   N_BUTTONS    = DEF_N_BUTTONS,
    parameter int                   PRESCALE     = DEF_PRESCALE,
    parameter int                   STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int                   REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int                   REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter logic [N_BUTTONS-1:0] REPEAT_MASK  = N_BUTTONS'(DEF_REPEAT_MASK)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 e_debug,
    input  logic [N_BUTTONS-1:0] btns_in,
    output logic [N_BUTTONS-1:0] btns_level,
    output logic [N_BUTTONS-1:0] btns_press,
    output logic [N_BUTTONS-1:0] btns_release
);

    localparam int              PS_W    = CNT_W(PRESCALE - 32'sd1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 32'sd1);

    logic [PS_W-1:0] pre_cnt_r;
    logic            tick_s;

    assign tick_s = (pre_cnt_r == PS_LAST);

    // Free-running prescaler; keeps counting in debug bypass
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_r <= '0;
        end else if (tick_s) begin
            pre_cnt_r <= '0;
        end else begin
            pre_cnt_r <= pre_cnt_r + PS_W'(1);
        end
    end

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        btn_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .REPEAT_EN    (REPEAT_MASK[i])
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .e_debug       (e_debug),
            .tick          (tick_s),
            .btn_in        (btns_in[i]),
            .level         (btns_level[i]),
            .press         (btns_press[i]),
            .release_pulse (btns_release[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: scenarios push expected press/release
// events (cycle, channel, kind); a negedge monitor pops and compares each pulse.
module tb_btn_conditioner;

    localparam int NB = 3;
    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;

    typedef struct packed {
        int at;
        int ch;
        int kind;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          e_debug = 1'b0;
    logic [NB-1:0] btns_in = '0;
    logic [NB-1:0] btns_level;
    logic [NB-1:0] btns_press;
    logic [NB-1:0] btns_release;

    int  cyc   = 0;
    int  tests = 0;
    int  fails = 0;
    int  t;
    ev_t exp_q[$];

    btn_conditioner #(
        .N_BUTTONS    (3),
        .PRESCALE     (4),
        .STABLE_TICKS (3),
        .REPEAT_DELAY (5),
        .REPEAT_RATE  (2),
        .REPEAT_MASK  (3'b110)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .e_debug      (e_debug),
        .btns_in      (btns_in),
        .btns_level   (btns_level),
        .btns_press   (btns_press),
        .btns_release (btns_release)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        return (k == K_PRESS) ? "press" : "release";
    endfunction

    task automatic push(input int at, input int ch, input int kind);
        ev_t e;
        e.at   = at;
        e.ch   = ch;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input int ch, input int kind);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL event: got %s ch%0d at cycle %0d, required no pulse",
                     kname(kind), ch, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.at != cyc || e.ch != ch || e.kind != kind) begin
                fails++;
                $display("FAIL event: got %s ch%0d at cycle %0d, required %s ch%0d at cycle %0d",
                         kname(kind), ch, cyc, kname(e.kind), e.ch, e.at);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [NB-1:0] got,
                             input logic [NB-1:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b at cycle %0d", name, got, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Tick edges fall on cycles that are multiples of 4 (prescaler cleared on edge 4)
    task automatic align();
        while (cyc % 4 != 0) step(1);
    endtask

    // Monitor: every press/release pulse must match the head of the scoreboard
    always @(negedge clk) begin
        for (int c = 0; c < NB; c++) begin
            if (btns_press[c])   check_event(c, K_PRESS);
            if (btns_release[c]) check_event(c, K_REL);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        step(4);
        check_val("reset_level", btns_level, 3'b000);
        check_val("reset_press", btns_press, 3'b000);
        check_val("reset_release", btns_release, 3'b000);
        rst = 1'b0;

        // Clean press and release on ch0 (no repeat: mask bit 0 clear)
        align();
        t = cyc;
        push(t + 12, 0, K_PRESS);
        btns_in[0] = 1'b1;
        step(20);
        check_val("clean_level_high", btns_level, 3'b001);
        step(20);
        t = cyc;
        push(t + 12, 0, K_REL);
        btns_in[0] = 1'b0;
        step(20);
        check_val("clean_level_low", btns_level, 3'b000);

        // Bounce on ch1: 5-cycle pulses never accumulate three ticks
        align();
        for (int k = 0; k < 12; k++) begin
            btns_in[1] = (k % 2 == 0) ? 1'b1 : 1'b0;
            step(5);
        end
        btns_in[1] = 1'b0;
        step(10);
        check_val("bounce_level", btns_level, 3'b000);

        // Hold-to-repeat on ch1; the repeat due with the fall is suppressed
        align();
        t = cyc;
        push(t + 12, 1, K_PRESS);
`ifdef BTN_AUTOREPEAT_EN
        push(t + 32, 1, K_PRESS);
        push(t + 40, 1, K_PRESS);
        push(t + 48, 1, K_PRESS);
`endif
        push(t + 56, 1, K_REL);
        btns_in[1] = 1'b1;
        step(44);
        btns_in[1] = 1'b0;
        step(30);
        check_val("repeat_level_low", btns_level, 3'b000);

        // Simultaneous press of ch0 and ch2
        align();
        t = cyc;
        push(t + 12, 0, K_PRESS);
        push(t + 12, 2, K_PRESS);
`ifdef BTN_AUTOREPEAT_EN
        push(t + 32, 2, K_PRESS);
`endif
        push(t + 36, 0, K_REL);
        push(t + 36, 2, K_REL);
        btns_in = 3'b101;
        step(20);
        check_val("simul_level_high", btns_level, 3'b101);
        step(4);
        btns_in = 3'b000;
        step(30);
        check_val("simul_level_low", btns_level, 3'b000);

        // Debug bypass: 1-cycle pulse on ch2, then leave bypass with ch0 held
        align();
        t = cyc;
        push(t + 3, 2, K_PRESS);
        push(t + 4, 0, K_PRESS);
        push(t + 4, 2, K_REL);
        e_debug    = 1'b1;
        btns_in[2] = 1'b1;
        step(1);
        btns_in[2] = 1'b0;
        btns_in[0] = 1'b1;
        step(2);
        check_val("bypass_level_t3", btns_level, 3'b100);
        step(1);
        check_val("bypass_level_t4", btns_level, 3'b001);
        step(4);
        e_debug = 1'b0;
        step(32);
        check_val("after_bypass_level", btns_level, 3'b001);
        push(t + 52, 0, K_REL);
        btns_in[0] = 1'b0;
        step(20);

        // Reset while ch1 is in REPEAT, input still held afterwards
        align();
        t = cyc;
        btns_in[1] = 1'b1;
        push(t + 12, 1, K_PRESS);
`ifdef BTN_AUTOREPEAT_EN
        push(t + 32, 1, K_PRESS);
`endif
        step(34);
        rst = 1'b1;
        step(1);
        check_val("midrst_level", btns_level, 3'b000);
        check_val("midrst_press", btns_press, 3'b000);
        check_val("midrst_release", btns_release, 3'b000);
        step(1);
        rst = 1'b0;
        push(t + 48, 1, K_PRESS);
        step(16);
        btns_in[1] = 1'b0;
        push(t + 64, 1, K_REL);
        step(30);

        step(10);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            while (exp_q.size() != 0) begin
                ev_t e;
                e = exp_q.pop_front();
                $display("FAIL missing: got no pulse, required %s ch%0d at cycle %0d",
                         kname(e.kind), e.ch, e.at);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
